dm_access_unit: RTL

Data-memory stage of the MIPS32 pipeline. It consumes the EX/DM pipeline register outputs and performs loads and stores over a req/ready memory handshake, with byte-lane alignment and load extension. It stalls upstream stages while an access is outstanding and owns the DM/WB pipeline register.

---
 rtl/dm_access_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dm_access_unit.sv
// Data-memory stage: aligned loads/stores over a req/ready handshake, lane
// steering and load extension, upstream stall, and the DM/WB pipeline register.
module dm_access_unit #(
    parameter int DM_OP_BIT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          alu_data_res_ex_dm,
    input  logic [31:0]          regfile_pre_data_w_ex_dm,
    input  logic [31:0]          regfile_data_b_ex_dm,
    input  logic                 halt_ex_dm,
    input  logic [4:0]           regfile_req_w_ex_dm,
    input  logic                 regfile_w_en_ex_dm,
    input  logic [DM_OP_BIT-1:0] datamem_op_ex_dm,
    input  logic                 datamem_w_en_ex_dm,
    input  logic                 memtoreg_ex_dm,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic                 stall,
    output logic [31:0]          regfile_data_w_dm_wb,
    output logic [4:0]           regfile_req_w_dm_wb,
    output logic                 regfile_w_en_dm_wb,
    output logic                 halt_dm_wb,
    output logic                 misalign_dm_wb
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] rdata_q;
    logic [1:0]  lane;
    logic        is_byte, is_half, is_word, signed_ld;
    logic        access, misalign, aligned_acc;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign lane = alu_data_res_ex_dm[1:0];

    always_comb begin
        is_byte   = (datamem_op_ex_dm == DM_OP_BIT'(1)) || (datamem_op_ex_dm == DM_OP_BIT'(2));
        is_half   = (datamem_op_ex_dm == DM_OP_BIT'(3)) || (datamem_op_ex_dm == DM_OP_BIT'(4));
        is_word   = !is_byte && !is_half;
        signed_ld = (datamem_op_ex_dm == DM_OP_BIT'(1)) || (datamem_op_ex_dm == DM_OP_BIT'(3));
        access    = memtoreg_ex_dm || datamem_w_en_ex_dm;
        misalign  = access && ((is_half && lane[0]) || (is_word && (lane != 2'b00)));
        aligned_acc = access && !misalign;
    end

    always_comb begin
        store_be   = 4'b1111;
        store_data = regfile_data_b_ex_dm;
        if (is_byte) begin
            store_be   = 4'b0001 << lane;
            store_data = {4{regfile_data_b_ex_dm[7:0]}};
        end else if (is_half) begin
            store_be   = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {2{regfile_data_b_ex_dm[15:0]}};
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = datamem_w_en_ex_dm;
    assign mem_addr  = {alu_data_res_ex_dm[31:2], 2'b00};
    assign mem_be    = datamem_w_en_ex_dm ? store_be : 4'b1111;
    assign mem_wdata = store_data;
    assign stall     = aligned_acc && (state != DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aligned_acc) state_nxt = BUSY;
            BUSY:    if (mem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == BUSY && mem_ready)
                rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
        if (is_byte)
            load_data = {{24{signed_ld & byte_sel[7]}}, byte_sel};
        else if (is_half)
            load_data = {{16{signed_ld & half_sel[15]}}, half_sel};
        else
            load_data = rdata_q;
    end

    // A stalled cycle writes a bubble so the access retires exactly once, from DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regfile_data_w_dm_wb <= '0;
            regfile_req_w_dm_wb  <= '0;
            regfile_w_en_dm_wb   <= 1'b0;
            halt_dm_wb           <= 1'b0;
            misalign_dm_wb       <= 1'b0;
        end else if (stall) begin
            regfile_data_w_dm_wb <= '0;
            regfile_req_w_dm_wb  <= '0;
            regfile_w_en_dm_wb   <= 1'b0;
            halt_dm_wb           <= 1'b0;
            misalign_dm_wb       <= 1'b0;
        end else begin
            regfile_data_w_dm_wb <= (memtoreg_ex_dm && !misalign) ? load_data : regfile_pre_data_w_ex_dm;
            regfile_req_w_dm_wb  <= regfile_req_w_ex_dm;
            regfile_w_en_dm_wb   <= regfile_w_en_ex_dm && !misalign;
            halt_dm_wb           <= halt_ex_dm;
            misalign_dm_wb       <= misalign;
        end
    end

endmodule
